alu_share_arb: RTL and testbench

//  Shares one instance of the 12-op one-hot ALU (add/sub/slt/sltu/and/nor/or/xor/sll/srl/sra/lui)

---
 rtl/alu_share_arb.sv | 162 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared 12-op one-hot ALU.
// Results go through a one-entry output stage and return to the owner with its tag.
module alu_share_arb #(
  parameter int TAG_W = 4,
  parameter bit FAIR  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [11:0]      r0_op,
  input  logic [31:0]      r0_src1,
  input  logic [31:0]      r0_src2,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [11:0]      r1_op,
  input  logic [31:0]      r1_src1,
  input  logic [31:0]      r1_src2,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             p0_valid,
  input  logic             p0_ready,
  output logic [31:0]      p0_result,
  output logic             p0_ovf,
  output logic             p0_err,
  output logic [TAG_W-1:0] p0_tag,
  output logic             p1_valid,
  input  logic             p1_ready,
  output logic [31:0]      p1_result,
  output logic             p1_ovf,
  output logic             p1_err,
  output logic [TAG_W-1:0] p1_tag
);

  function automatic logic is_onehot12(input logic [11:0] v);
    return (v != 12'h000) && ((v & (v - 12'h001)) == 12'h000);
  endfunction

  logic             r_stg_valid;
  logic             r_stg_id;
  logic             r_last_grant;
  logic [31:0]      r_stg_result;
  logic             r_stg_ovf;
  logic             r_stg_err;
  logic [TAG_W-1:0] r_stg_tag;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_free;
  logic             w_accept;
  logic [11:0]      w_op;
  logic [31:0]      w_src1;
  logic [31:0]      w_src2;
  logic [TAG_W-1:0] w_tag;
  logic             w_sub_mode;
  logic [31:0]      w_b_in;
  logic [31:0]      w_sum;
  logic             w_cout;
  logic             w_slt;
  logic             w_sltu;
  logic [31:0]      w_sra;
  logic             w_alu_ovf;
  logic [31:0]      w_alu_result;
  logic             w_err;
  logic [31:0]      w_result;
  logic             w_ovf;

  // r0 wins unless r1 alone is valid, or both are valid under round-robin and r0 went last
  assign w_grant0 = r0_valid & (~r1_valid | (FAIR == 1'b0) | r_last_grant);
  assign w_grant1 = r1_valid & ~w_grant0;
  assign w_free   = ~r_stg_valid | (r_stg_id ? p1_ready : p0_ready);
  assign r0_ready = w_grant0 & w_free & ~reset;
  assign r1_ready = w_grant1 & w_free & ~reset;
  assign w_accept = r0_ready | r1_ready;

  // Operand mux from the granted requester; zeros when idle
  always_comb begin
    w_op   = 12'h000;
    w_src1 = 32'h0000_0000;
    w_src2 = 32'h0000_0000;
    w_tag  = '0;
    if (w_grant0) begin
      w_op   = r0_op;
      w_src1 = r0_src1;
      w_src2 = r0_src2;
      w_tag  = r0_tag;
    end else if (w_grant1) begin
      w_op   = r1_op;
      w_src1 = r1_src1;
      w_src2 = r1_src2;
      w_tag  = r1_tag;
    end else begin
      w_op   = 12'h000;
      w_src1 = 32'h0000_0000;
      w_src2 = 32'h0000_0000;
      w_tag  = '0;
    end
  end

  // One adder serves add, sub, slt and sltu; overflow always reflects the adder
  assign w_sub_mode       = w_op[1] | w_op[2] | w_op[3];
  assign w_b_in           = w_sub_mode ? ~w_src2 : w_src2;
  assign {w_cout, w_sum}  = {1'b0, w_src1} + {1'b0, w_b_in} + {32'd0, w_sub_mode};
  assign w_alu_ovf        = (w_src1[31] == w_b_in[31]) & (w_sum[31] != w_src1[31]);
  assign w_slt            = (w_src1[31] & ~w_src2[31]) | (~(w_src1[31] ^ w_src2[31]) & w_sum[31]);
  assign w_sltu           = ~w_cout;
  assign w_sra            = $signed(w_src2) >>> w_src1[4:0];

  assign w_alu_result =
      ({32{w_op[0] | w_op[1]}} & w_sum)
    | ({32{w_op[2]}}  & {31'd0, w_slt})
    | ({32{w_op[3]}}  & {31'd0, w_sltu})
    | ({32{w_op[4]}}  & (w_src1 & w_src2))
    | ({32{w_op[5]}}  & ~(w_src1 | w_src2))
    | ({32{w_op[6]}}  & (w_src1 | w_src2))
    | ({32{w_op[7]}}  & (w_src1 ^ w_src2))
    | ({32{w_op[8]}}  & (w_src2 << w_src1[4:0]))
    | ({32{w_op[9]}}  & (w_src2 >> w_src1[4:0]))
    | ({32{w_op[10]}} & w_sra)
    | ({32{w_op[11]}} & {w_src2[15:0], 16'h0000});

  assign w_err    = ~is_onehot12(w_op);
  assign w_result = w_err ? 32'h0000_0000 : w_alu_result;
  assign w_ovf    = w_err ? 1'b0 : w_alu_ovf;

  // Output stage: reload on accept (even while draining), clear on drain, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_valid  <= 1'b0;
      r_stg_id     <= 1'b0;
      r_stg_result <= 32'h0000_0000;
      r_stg_ovf    <= 1'b0;
      r_stg_err    <= 1'b0;
      r_stg_tag    <= '0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_stg_valid  <= 1'b1;
      r_stg_id     <= w_grant1;
      r_stg_result <= w_result;
      r_stg_ovf    <= w_ovf;
      r_stg_err    <= w_err;
      r_stg_tag    <= w_tag;
      r_last_grant <= w_grant1;
    end else if (w_free) begin
      r_stg_valid  <= 1'b0;
    end else begin
      r_stg_valid  <= r_stg_valid;
    end
  end

  assign p0_valid  = r_stg_valid & ~r_stg_id;
  assign p1_valid  = r_stg_valid & r_stg_id;
  assign p0_result = r_stg_result;
  assign p1_result = r_stg_result;
  assign p0_ovf    = r_stg_ovf;
  assign p1_ovf    = r_stg_ovf;
  assign p0_err    = r_stg_err;
  assign p1_err    = r_stg_err;
  assign p0_tag    = r_stg_tag;
  assign p1_tag    = r_stg_tag;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: op vector table plus hand-written arbitration,
// backpressure and reset sequences; a FAIR=0 instance shares the stimulus.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid, p0_ready, p1_ready;
  logic [11:0] r0_op, r1_op;
  logic [31:0] r0_src1, r0_src2, r1_src1, r1_src2;
  logic [3:0]  r0_tag, r1_tag;

  logic        r0_ready, r1_ready, p0_valid, p1_valid, p0_ovf, p1_ovf, p0_err, p1_err;
  logic [31:0] p0_result, p1_result;
  logic [3:0]  p0_tag, p1_tag;

  logic        f_r0_ready, f_r1_ready, f_p0_valid, f_p1_valid, f_p0_ovf, f_p1_ovf, f_p0_err, f_p1_err;
  logic [31:0] f_p0_result, f_p1_result;
  logic [3:0]  f_p0_tag, f_p1_tag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.TAG_W(4), .FAIR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_src1(r0_src1), .r0_src2(r0_src2), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_src1(r1_src1), .r1_src2(r1_src2), .r1_tag(r1_tag),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_result(p0_result), .p0_ovf(p0_ovf), .p0_err(p0_err), .p0_tag(p0_tag),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_result(p1_result), .p1_ovf(p1_ovf), .p1_err(p1_err), .p1_tag(p1_tag)
  );

  alu_share_arb #(.TAG_W(4), .FAIR(1'b0)) dut_fixed (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(f_r0_ready), .r0_op(r0_op), .r0_src1(r0_src1), .r0_src2(r0_src2), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(f_r1_ready), .r1_op(r1_op), .r1_src1(r1_src1), .r1_src2(r1_src2), .r1_tag(r1_tag),
    .p0_valid(f_p0_valid), .p0_ready(p0_ready), .p0_result(f_p0_result), .p0_ovf(f_p0_ovf), .p0_err(f_p0_err), .p0_tag(f_p0_tag),
    .p1_valid(f_p1_valid), .p1_ready(p1_ready), .p1_result(f_p1_result), .p1_ovf(f_p1_ovf), .p1_err(f_p1_err), .p1_tag(f_p1_tag)
  );

  typedef struct {
    logic        sel;
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        ovf;
    logic        chk_ovf;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic sel, input logic [11:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [3:0] tag);
    if (sel == 1'b0) begin
      r0_op = op; r0_src1 = s1; r0_src2 = s2; r0_tag = tag;
    end else begin
      r1_op = op; r1_src1 = s1; r1_src2 = s2; r1_tag = tag;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_last;
    logic g;
    int   k0, k1;

    //           sel  op       src1          src2          tag    result        ovf   chk  err
    vecs[0]  = '{1'b0, 12'h001, 32'd5,        32'd7,        4'd3,  32'd12,       1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 12'h002, 32'h80000000, 32'd1,        4'd1,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 12'h004, 32'h80000000, 32'd1,        4'd2,  32'd1,        1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 12'h008, 32'h80000000, 32'd1,        4'd4,  32'd0,        1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 12'h010, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd5,  32'h00F000F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 12'h020, 32'hF0F0F0F0, 32'h0F0F0000, 4'd6,  32'h00000F0F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 12'h040, 32'h12340000, 32'h00005678, 4'd7,  32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 12'h080, 32'hFFFF0000, 32'h0F0F0F0F, 4'd8,  32'hF0F00F0F, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 12'h100, 32'h00000024, 32'h00000011, 4'd9,  32'h00000110, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 12'h200, 32'd8,        32'h80000000, 4'd10, 32'h00800000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 12'h400, 32'd8,        32'h80000000, 4'd11, 32'hFF800000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 12'h800, 32'd0,        32'h00001234, 4'd12, 32'h12340000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 12'h001, 32'h7FFFFFFF, 32'd1,        4'd13, 32'h80000000, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 12'h003, 32'd5,        32'd7,        4'd14, 32'd0,        1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 12'h000, 32'd5,        32'd7,        4'd15, 32'd0,        1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 12'h002, 32'd3,        32'd5,        4'd0,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b0; p0_ready = 1'b1; p1_ready = 1'b1;
    set_req(1'b0, 12'h001, 32'd1, 32'd1, 4'd1);
    set_req(1'b1, 12'h001, 32'd1, 32'd1, 4'd1);
    #8;
    check("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
    check("rst_p0_valid", {31'd0, p0_valid}, 32'd0);
    check("rst_p1_valid", {31'd0, p1_valid}, 32'd0);
    check("rst_result", p0_result, 32'd0);
    check("rst_tag", {28'd0, p1_tag}, 32'd0);
    tick();
    reset = 1'b0;
    r0_valid = 1'b0;

    // Op table, alternating requesters, back-to-back with both consumers ready
    for (int i = 0; i < 16; i++) begin
      set_req(vecs[i].sel, vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].tag);
      r0_valid = ~vecs[i].sel;
      r1_valid = vecs[i].sel;
      #3;
      check($sformatf("v%0d_ready_own", i), {31'd0, vecs[i].sel ? r1_ready : r0_ready}, 32'd1);
      check($sformatf("v%0d_ready_oth", i), {31'd0, vecs[i].sel ? r0_ready : r1_ready}, 32'd0);
      tick();
      check($sformatf("v%0d_pvalid_own", i), {31'd0, vecs[i].sel ? p1_valid : p0_valid}, 32'd1);
      check($sformatf("v%0d_pvalid_oth", i), {31'd0, vecs[i].sel ? p0_valid : p1_valid}, 32'd0);
      check($sformatf("v%0d_result", i), vecs[i].sel ? p1_result : p0_result, vecs[i].res);
      check($sformatf("v%0d_tag", i), {28'd0, vecs[i].sel ? p1_tag : p0_tag}, {28'd0, vecs[i].tag});
      check($sformatf("v%0d_err", i), {31'd0, vecs[i].sel ? p1_err : p0_err}, {31'd0, vecs[i].err});
      if (vecs[i].chk_ovf)
        check($sformatf("v%0d_ovf", i), {31'd0, vecs[i].sel ? p1_ovf : p0_ovf}, {31'd0, vecs[i].ovf});
    end

    // Contention: last grant was r1, so r0 leads and the two alternate
    exp_last = 1'b1; k0 = 0; k1 = 0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_req(1'b0, 12'h001, 32'(k0), 32'd100, 4'(k0));
      set_req(1'b1, 12'h002, 32'd1000, 32'(k1), 4'(k1 + 8));
      #3;
      g = ~exp_last;
      check($sformatf("rr%0d_r0_ready", c), {31'd0, r0_ready}, {31'd0, ~g});
      check($sformatf("rr%0d_r1_ready", c), {31'd0, r1_ready}, {31'd0, g});
      tick();
      exp_last = g;
      if (g == 1'b0) begin
        check($sformatf("rr%0d_p0_valid", c), {31'd0, p0_valid}, 32'd1);
        check($sformatf("rr%0d_p0_result", c), p0_result, 32'(100 + k0));
        check($sformatf("rr%0d_p0_tag", c), {28'd0, p0_tag}, 32'(k0));
        k0++;
      end else begin
        check($sformatf("rr%0d_p1_valid", c), {31'd0, p1_valid}, 32'd1);
        check($sformatf("rr%0d_p1_result", c), p1_result, 32'(1000 - k1));
        check($sformatf("rr%0d_p1_tag", c), {28'd0, p1_tag}, 32'(k1 + 8));
        k1++;
      end
    end

    // Backpressure: r0 response held while p0_ready is low blocks both requesters
    r1_valid = 1'b0;
    set_req(1'b0, 12'h001, 32'd1, 32'd1, 4'd5);
    tick();
    check("bp_first_p0_result", p0_result, 32'd2);
    p0_ready = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    set_req(1'b0, 12'h001, 32'd10, 32'd20, 4'd6);
    set_req(1'b1, 12'h040, 32'h0000000F, 32'h000000F0, 4'd7);
    for (int c = 0; c < 3; c++) begin
      #3;
      check($sformatf("bp%0d_r0_ready", c), {31'd0, r0_ready}, 32'd0);
      check($sformatf("bp%0d_r1_ready", c), {31'd0, r1_ready}, 32'd0);
      tick();
      check($sformatf("bp%0d_p0_valid", c), {31'd0, p0_valid}, 32'd1);
      check($sformatf("bp%0d_p0_result", c), p0_result, 32'd2);
      check($sformatf("bp%0d_p0_tag", c), {28'd0, p0_tag}, 32'd5);
    end
    p0_ready = 1'b1;
    #3;
    check("bp_rel_r1_ready", {31'd0, r1_ready}, 32'd1);
    check("bp_rel_r0_ready", {31'd0, r0_ready}, 32'd0);
    tick();
    check("bp_rel_p1_valid", {31'd0, p1_valid}, 32'd1);
    check("bp_rel_p0_valid", {31'd0, p0_valid}, 32'd0);
    check("bp_rel_p1_result", p1_result, 32'h000000FF);
    check("bp_rel_p1_tag", {28'd0, p1_tag}, 32'd7);
    r1_valid = 1'b0;
    #3;
    check("bp_next_r0_ready", {31'd0, r0_ready}, 32'd1);
    tick();
    check("bp_next_p0_result", p0_result, 32'd30);
    check("bp_next_p0_tag", {28'd0, p0_tag}, 32'd6);

    // Reset while r1 owns a held response
    r0_valid = 1'b0; r1_valid = 1'b1; p1_ready = 1'b0;
    set_req(1'b1, 12'h001, 32'd40, 32'd2, 4'd9);
    #3;
    check("mr_r1_ready", {31'd0, r1_ready}, 32'd1);
    tick();
    r1_valid = 1'b0;
    tick();
    check("mr_p1_held", {31'd0, p1_valid}, 32'd1);
    check("mr_p1_result", p1_result, 32'd42);
    #1;
    reset = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check("mr_p1_valid_cleared", {31'd0, p1_valid}, 32'd0);
    check("mr_result_cleared", p1_result, 32'd0);
    check("mr_r0_ready_in_reset", {31'd0, r0_ready}, 32'd0);
    tick();
    reset = 1'b0;
    p0_ready = 1'b1; p1_ready = 1'b1;
    set_req(1'b0, 12'h001, 32'd1, 32'd2, 4'd1);
    set_req(1'b1, 12'h001, 32'd3, 32'd4, 4'd2);
    exp_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      g = ~exp_last;
      check($sformatf("ar%0d_r0_ready", c), {31'd0, r0_ready}, {31'd0, ~g});
      check($sformatf("ar%0d_r1_ready", c), {31'd0, r1_ready}, {31'd0, g});
      check($sformatf("fx%0d_r0_ready", c), {31'd0, f_r0_ready}, 32'd1);
      check($sformatf("fx%0d_r1_ready", c), {31'd0, f_r1_ready}, 32'd0);
      tick();
      exp_last = g;
      check($sformatf("fx%0d_p0_valid", c), {31'd0, f_p0_valid}, 32'd1);
      check($sformatf("fx%0d_p0_result", c), f_p0_result, 32'd3);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
